// File: rtl/mux_gate_pkg.sv
// ---------------------------------------------------------------------------
// mux_gate_pkg
// Shared types and helpers for the bit-serial mux-gate sequencer.
//   op_e        : 3-bit operation code (NOT..BUF)
//   state_e     : sequencer FSM states (IDLE, EXEC, DONE)
//   mux_drive_t : one set of inputs for the shared 2:1 mux
//   op_steps()  : number of mux evaluations (S) needed per result bit
// ---------------------------------------------------------------------------
package mux_gate_pkg;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_BUF  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic d0;
        logic d1;
        logic sel;
    } mux_drive_t;

    // Single-step gates reach the result in one mux pass; the others need a
    // second pass that consumes the scratch bit r0.
    function automatic logic [1:0] op_steps(op_e op);
        case (op)
            OP_XOR, OP_NAND, OP_NOR, OP_XNOR: op_steps = 2'd2;
            default:                          op_steps = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/mux.sv
// ---------------------------------------------------------------------------
// mux
// Plain 2:1 multiplexer; the only logic element the sequencer computes with.
//   d0, d1 : data inputs
//   sel    : select (0 -> d0, 1 -> d1)
//   y      : output
// ---------------------------------------------------------------------------
module mux (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_gate_sequencer.sv
// ---------------------------------------------------------------------------
// mux_gate_sequencer
// Bit-serial logic unit: evaluates a selected 2-input gate over WIDTH-bit
// operands, one mux evaluation per cycle, using a single shared 2:1 mux.
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : request present      in_ready  : accepting (IDLE only)
//   op, a, b    : opcode and operands, captured on the accept edge
//   out_valid   : result available (DONE only)
//   out_ready   : sink accepts result
//   out_result  : result register, stable while out_valid is high
//   busy        : high in EXEC or DONE
// ---------------------------------------------------------------------------
module mux_gate_sequencer
    import mux_gate_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam int              IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e           state_q, state_d;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic             step_q;
    logic [1:0]       r_q;

    logic             a_bit, b_bit;
    logic             last_step, last_bit;
    mux_drive_t       drv;
    logic             mux_y;

    // Operand bit at bit_idx. A compare-and-pick loop keeps the select legal
    // even when WIDTH is not a power of two (or is 1).
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        a_bit = 1'b0;
        b_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bit_idx_q == IDX_W'(i)) begin
                a_bit = a_q[i];
                b_bit = b_q[i];
            end
        end
    end

    assign last_step = (op_steps(op_q) == 2'd1) ? 1'b1 : step_q;
    assign last_bit  = (bit_idx_q == LAST_IDX);

    // Mux program: one (d0, d1, sel) triple per op and step. Outside EXEC
    // the mux is parked at mux(0,0,0).
    always_comb begin
        drv = '0;
        if (state_q == EXEC) begin
            case (op_q)
                OP_NOT:  drv = '{d0: 1'b1,  d1: 1'b0,  sel: a_bit};
                OP_AND:  drv = '{d0: 1'b0,  d1: b_bit, sel: a_bit};
                OP_OR:   drv = '{d0: b_bit, d1: 1'b1,  sel: a_bit};
                OP_XOR:  drv = !step_q ? '{d0: 1'b1,  d1: 1'b0,   sel: b_bit}
                                       : '{d0: b_bit, d1: r_q[0], sel: a_bit};
                OP_NAND: drv = !step_q ? '{d0: 1'b0, d1: b_bit, sel: a_bit}
                                       : '{d0: 1'b1, d1: 1'b0,  sel: r_q[0]};
                OP_NOR:  drv = !step_q ? '{d0: b_bit, d1: 1'b1, sel: a_bit}
                                       : '{d0: 1'b1,  d1: 1'b0, sel: r_q[0]};
                OP_XNOR: drv = !step_q ? '{d0: 1'b1,   d1: 1'b0,  sel: b_bit}
                                       : '{d0: r_q[0], d1: b_bit, sel: a_bit};
                OP_BUF:  drv = '{d0: 1'b0,  d1: 1'b1,  sel: a_bit};
                default: drv = '0;
            endcase
        end
    end

    mux u_mux (
        .d0  (drv.d0),
        .d1  (drv.d1),
        .sel (drv.sel),
        .y   (mux_y)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so all
        // registers update together from pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = EXEC;
            EXEC:    if (last_step && last_bit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            EXEC:    busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath: operand capture, counters, scratch bits and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_NOT;
            a_q       <= '0;
            b_q       <= '0;
            bit_idx_q <= '0;
            step_q    <= 1'b0;
            r_q       <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q      <= op_e'(op);
                        a_q       <= a;
                        b_q       <= b;
                        bit_idx_q <= '0;
                        step_q    <= 1'b0;
                    end
                end
                EXEC: begin
                    r_q[step_q] <= mux_y;
                    if (last_step) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            if (bit_idx_q == IDX_W'(i)) result_q[i] <= mux_y;
                        end
                        step_q <= 1'b0;
                        // bit_idx saturates at WIDTH-1; the FSM leaves EXEC here.
                        if (!last_bit) bit_idx_q <= bit_idx_q + 1'b1;
                    end else begin
                        step_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_result = result_q;

endmodule

// File: tb/tb_mux_gate_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_gate_sequencer
// Scoreboard bench: drivers push expected {result, latency} when issuing a
// request; per-instance monitors pop and compare when out_valid rises, and
// check out_result stability while out_valid stays high. Two instances:
// WIDTH=4 for directed vectors and WIDTH=1 for the exhaustive sweep.
// ---------------------------------------------------------------------------
module tb_mux_gate_sequencer;

    typedef struct {
        logic [3:0] res;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH=4 instance signals
    logic       iv4, ir4, ov4, ordy4, busy4;
    logic [2:0] op4;
    logic [3:0] a4, b4, res4;
    // WIDTH=1 instance signals
    logic       iv1, ir1, ov1, ordy1, busy1;
    logic [2:0] op1;
    logic [0:0] a1, b1, res1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t sb4[$];
    exp_t sb1[$];

    mux_gate_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .op(op4),
        .a(a4), .b(b4), .out_valid(ov4), .out_ready(ordy4),
        .out_result(res4), .busy(busy4)
    );

    mux_gate_sequencer #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op(op1),
        .a(a1), .b(b1), .out_valid(ov1), .out_ready(ordy1),
        .out_result(res1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- monitors ----------------
    int         acc4 = 0, acc1 = 0;
    logic       ovp4 = 1'b0, ovp1 = 1'b0;
    logic [3:0] held4;
    logic [0:0] held1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && iv4 && ir4) acc4 = cyc + 1;
        if (ov4 && !ovp4) begin
            if (sb4.size() == 0) begin
                check("w4_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb4.pop_front();
                check("w4_result", res4, e.res);
                check("w4_latency", cyc - acc4, e.lat);
            end
            held4 = res4;
        end else if (ov4) begin
            check("w4_result_stable", res4, held4);
        end
        ovp4 = ov4;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && iv1 && ir1) acc1 = cyc + 1;
        if (ov1 && !ovp1) begin
            if (sb1.size() == 0) begin
                check("w1_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb1.pop_front();
                check("w1_result", res1, e.res);
                check("w1_latency", cyc - acc1, e.lat);
            end
            held1 = res1;
        end else if (ov1) begin
            check("w1_result_stable", res1, held1);
        end
        ovp1 = ov1;
    end

    // ---------------- drivers ----------------
    task automatic push4(input logic [3:0] r, input int lat);
        exp_t e;
        e.res = r;
        e.lat = lat;
        sb4.push_back(e);
    endtask

    task automatic start4(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
        int n = 0;
        while (!ir4 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ir4) check("w4_ready_timeout", ir4, 1);
        op4 = o; a4 = x; b4 = y; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        // Scramble inputs after accept; the result must not depend on them.
        op4 = ~o; a4 = ~x; b4 = ~y;
    endtask

    task automatic wait_idle4();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(sb4.size() == 0 && ir4) && n < 200);
        check("w4_completed_in_time", (sb4.size() == 0 && ir4), 1);
    endtask

    task automatic run4(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                        input logic [3:0] r, input int lat);
        push4(r, lat);
        start4(o, x, y);
        wait_idle4();
    endtask

    task automatic run1(input logic [2:0] o, input logic x, input logic y,
                        input logic r, input int lat);
        exp_t e;
        int n = 0;
        e.res = {3'b000, r};
        e.lat = lat;
        sb1.push_back(e);
        while (!ir1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        op1 = o; a1 = x; b1 = y; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        a1 = ~x; b1 = ~y;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(sb1.size() == 0 && ir1) && n < 100);
        check("w1_completed_in_time", (sb1.size() == 0 && ir1), 1);
    endtask

    // Reference gate for the WIDTH=1 sweep, written with plain operators.
    function automatic logic ref_gate(input int o, input logic x, input logic y);
        case (o)
            0:       ref_gate = ~x;
            1:       ref_gate = x & y;
            2:       ref_gate = x | y;
            3:       ref_gate = x ^ y;
            4:       ref_gate = ~(x & y);
            5:       ref_gate = ~(x | y);
            6:       ref_gate = ~(x ^ y);
            default: ref_gate = x;
        endcase
    endfunction

    function automatic int ref_steps(input int o);
        ref_steps = (o >= 3 && o <= 6) ? 2 : 1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        iv4 = 1'b0; op4 = '0; a4 = '0; b4 = '0; ordy4 = 1'b1;
        iv1 = 1'b0; op1 = '0; a1 = '0; b1 = '0; ordy1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", ir4, 1);
        check("reset_out_valid", ov4, 0);
        check("reset_busy", busy4, 0);
        check("reset_out_result", res4, 0);
        rst = 1'b0;

        // Directed vectors, a=1100 b=1010.
        run4(3'd3, 4'b1100, 4'b1010, 4'b0110, 8);  // XOR
        run4(3'd1, 4'b1100, 4'b1010, 4'b1000, 4);  // AND
        run4(3'd4, 4'b1100, 4'b1010, 4'b0111, 8);  // NAND
        run4(3'd2, 4'b1100, 4'b1010, 4'b1110, 4);  // OR
        run4(3'd5, 4'b1100, 4'b1010, 4'b0001, 8);  // NOR
        run4(3'd6, 4'b1100, 4'b1010, 4'b1001, 8);  // XNOR
        run4(3'd0, 4'b1100, 4'b1010, 4'b0011, 4);  // NOT
        run4(3'd7, 4'b1100, 4'b1010, 4'b1100, 4);  // BUF

        // Output backpressure: stall 5 cycles in DONE with a competing request.
        ordy4 = 1'b0;
        push4(4'b0110, 8);
        start4(3'd3, 4'b1100, 4'b1010);
        begin
            int n = 0;
            while (!ov4 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            check("bp_reached_done", ov4, 1);
        end
        for (int i = 0; i < 5; i++) begin
            op4 = 3'd1; a4 = 4'b0101; b4 = 4'b0011; iv4 = 1'b1;
            @(posedge clk); #1;
            check("bp_in_ready_low", ir4, 0);
            check("bp_out_valid_held", ov4, 1);
            check("bp_out_result_held", res4, 4'b0110);
        end
        iv4 = 1'b0;
        ordy4 = 1'b1;
        @(posedge clk); #1;  // result handshake edge
        check("bp_in_ready_after_handshake", ir4, 1);
        push4(4'b0111, 4);
        op4 = 3'd2; a4 = 4'b0101; b4 = 4'b0011; iv4 = 1'b1;  // OR
        @(posedge clk); #1;
        iv4 = 1'b0;
        check("bp_next_accepted", busy4, 1);
        wait_idle4();

        // Reset mid-EXEC during an XOR; the pending result is discarded.
        start4(3'd3, 4'b1100, 4'b1010);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", ir4, 1);
        check("rst_out_valid", ov4, 0);
        check("rst_busy", busy4, 0);
        check("rst_out_result", res4, 0);
        run4(3'd3, 4'b1100, 4'b1010, 4'b0110, 8);

        // Exhaustive sweep at WIDTH=1.
        for (int o = 0; o < 8; o++) begin
            for (int v = 0; v < 4; v++) begin
                logic x, y;
                x = v[1];
                y = v[0];
                run1(3'(o), x, y, ref_gate(o, x, y), ref_steps(o));
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb4_drained", sb4.size(), 0);
        check("sb1_drained", sb1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_gate_sequencer.md
# mux_gate_sequencer

Bit-serial multi-function logic unit that evaluates a selected 2-input gate over WIDTH-bit operands using exactly one shared 2:1 `mux` instance. The sequencer owns the mux: every cycle it chooses the mux's d0, d1 and sel from constants, operand bits or scratch registers. It sits between a valid/ready request source and a valid/ready result sink, and it processes one request at a time.

## Interface
- WIDTH, default 4: operand and result width in bits, minimum 1.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  request present.
- in_ready  output  1  sequencer accepts a request; high only in IDLE.
- op  input  3  operation code, sampled on the accept edge.
- a  input  WIDTH  operand A, sampled on the accept edge.
- b  input  WIDTH  operand B, sampled on the accept edge.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  sink accepts the result.
- out_result  output  WIDTH  result register; held stable while out_valid is high.
- busy  output  1  high in EXEC or DONE.

## Operation
- Opcodes and per-bit mux programs. Each line gives mux(d0, d1, sel) for one step. r0 and r1 are 1-bit scratch registers. The result bit is the output of the last step.
  - 0 NOT: r0=mux(1,0,a). S=1.
  - 1 AND: r0=mux(0,b,a). S=1.
  - 2 OR: r0=mux(b,1,a). S=1.
  - 3 XOR: r0=mux(1,0,b); r1=mux(b,r0,a). S=2.
  - 4 NAND: r0=mux(0,b,a); r1=mux(1,0,r0). S=2.
  - 5 NOR: r0=mux(b,1,a); r1=mux(1,0,r0). S=2.
  - 6 XNOR: r0=mux(1,0,b); r1=mux(r0,b,a). S=2.
  - 7 BUF: r0=mux(0,1,a). S=1.
- In every step, a and b denote the captured operand bits at index bit_idx.
- The FSM has three states: IDLE, EXEC and DONE.
- IDLE
  - in_ready=1.
  - On in_valid: capture op, a and b; set bit_idx=0 and step=0; go to EXEC.
- EXEC, one mux evaluation per cycle.
  - Write the mux output into r[step].
  - On the last step of a bit, also write out_result[bit_idx].
  - After the last step of a bit: if bit_idx==WIDTH-1, go to DONE. Otherwise set step=0 and increment bit_idx.
  - After any other step: increment step.
- DONE
  - out_valid=1.
  - On out_ready: go to IDLE.
  - out_result holds its value until the next request's writes overwrite it.
- Counters
  - bit_idx is $clog2(WIDTH) bits wide, minimum 1 bit, and never exceeds WIDTH-1.
  - step is 1 bit wide.
- The mux select inputs are driven combinationally from state, op, step and the captured operands. The mux is never left undriven. In IDLE and DONE the mux is driven with mux(0,0,0).

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_result=0, r0=r1=0, bit_idx=0, step=0.
- The accept edge is the rising edge where in_valid && in_ready is high.
- out_valid rises exactly WIDTH*S edges after the accept edge.
  - WIDTH=4, XOR: 8 edges.
  - WIDTH=4, AND: 4 edges.
- Minimum request-to-request spacing is WIDTH*S+2 cycles. One IDLE cycle always follows the result handshake, so there is no same-cycle result/request overlap.
- in_valid in EXEC or DONE is ignored. in_ready=0 in those states, and operands are not resampled.
- out_ready low in DONE stalls indefinitely. out_result and out_valid stay stable during the stall.
- op, a and b may change freely after the accept edge without affecting the result.
- rst asserted in any state, including mid-EXEC or DONE with out_valid high, returns all registers to their reset values on that edge. The pending result is discarded.

## Structure
- Shared package mux_gate_pkg holds:
  - the op_e enum (3-bit, values 0–7 as above);
  - the state_e enum (IDLE, EXEC, DONE);
  - the function op_steps(op_e) returning S.
- The only sub-module is the existing mux, instantiated exactly once (u_mux). No gate is computed with `&`, `|` or `^`; all logic values originate from the mux output.

## Test plan
- WIDTH=4, op=XOR, a=4'b1100, b=4'b1010 → out_valid after 8 edges, out_result=4'b0110.
- op=AND, then op=NAND, both with a=4'b1100, b=4'b1010:
  - AND → 4'b1000 after 4 edges.
  - NAND → 4'b0111 after 8 edges.
- op=OR, then NOR, then XNOR, then NOT, same operands:
  - OR → 4'b1110.
  - NOR → 4'b0001.
  - XNOR → 4'b1001.
  - NOT → 4'b0011.
- Output backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_result is stable.
  - in_ready stays 0; a concurrent in_valid with different operands is not captured.
  - After out_ready, the next request is accepted one cycle later.
- Pulse rst during EXEC at XOR step 3.
  - Next cycle: IDLE, out_result=0, in_ready=1.
  - A fresh XOR request then completes normally in 8 edges.
- Exhaustive check at WIDTH=1: all 8 ops × 4 operand pairs.
  - Each result matches the reference gate.
  - Latency is S edges for every case.
